bm_dag3_solver: RTL and testbench

- Sequential inverse of the 3-level adder/subtractor DAG micro-benchmark.
- Accepts a target output value and exhaustively enumerates every (a_in, b_in) operand pair.
- Evaluates the same DAG equations on each pair and streams out every pair whose DAG output equals the target over a valid/ready interface, then reports a completion pulse with the match count.
- Used as a regression companion to the forward DAG block: forward block is the producer of out, this block is the consumer/solver.

---
 rtl/bm_dag3_solver.sv | 135 +++++++++++++
 tb/tb_bm_dag3_solver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bm_dag3_solver.sv
// Exhaustive inverse solver for the 3-level adder/subtractor DAG: scans every
// (a_in, b_in) pair, streams the ones whose DAG output equals the target.
module bm_dag3_solver #(
   parameter int BITS = 2
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                tgt_valid,
   output logic                tgt_ready,
   input  logic [BITS-1:0]     tgt_value,
   output logic                sol_valid,
   input  logic                sol_ready,
   output logic [BITS-1:0]     sol_a,
   output logic [BITS-1:0]     sol_b,
   output logic                done,
   output logic [2*BITS:0]     match_count,
   output logic                busy
);

   localparam int CW = 2 * BITS;
   localparam int MW = 2 * BITS + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_EMIT,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [BITS-1:0] target_q, target_d;
   logic [BITS-1:0] sol_a_q, sol_a_d;
   logic [BITS-1:0] sol_b_q, sol_b_d;
   logic            sol_valid_q, sol_valid_d;
   logic [MW-1:0]   match_count_q, match_count_d;
   logic            last_hit_q, last_hit_d;

   logic [BITS-1:0] cand_x, cand_y;
   logic [BITS-1:0] dag_a, dag_b, dag_c, dag_d, dag_f;
   logic            cand_last, cand_match;

   // The counter holds x in its upper half so y naturally increments fastest.
   always_comb begin
      cand_x     = cnt_q[CW-1:BITS];
      cand_y     = cnt_q[BITS-1:0];
      dag_c      = cand_x + cand_y;
      dag_a      = cand_y + dag_c;
      dag_b      = cand_x - dag_c;
      dag_d      = dag_b + cand_y;
      dag_f      = dag_a + dag_b + dag_c + dag_d;
      cand_last  = &cnt_q;
      cand_match = (dag_f == target_q);
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      target_d      = target_q;
      sol_a_d       = sol_a_q;
      sol_b_d       = sol_b_q;
      sol_valid_d   = sol_valid_q;
      match_count_d = match_count_q;
      last_hit_d    = last_hit_q;

      case (state_q)
         S_IDLE: begin
            if (tgt_valid) begin
               target_d      = tgt_value;
               match_count_d = '0;
               cnt_d         = '0;
               state_d       = S_SCAN;
            end
         end
         S_SCAN: begin
            cnt_d = cnt_q + 1'b1;
            if (cand_match) begin
               sol_a_d       = cand_x;
               sol_b_d       = cand_y;
               sol_valid_d   = 1'b1;
               match_count_d = match_count_q + 1'b1;
               last_hit_d    = cand_last;
               state_d       = S_EMIT;
            end else if (cand_last) begin
               state_d = S_DONE;
            end
         end
         // The counter already wrapped when the final candidate matched, so
         // last_hit_q is the only record that the scan is finished.
         S_EMIT: begin
            if (sol_ready) begin
               sol_valid_d = 1'b0;
               state_d     = last_hit_q ? S_DONE : S_SCAN;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         target_q      <= '0;
         sol_a_q       <= '0;
         sol_b_q       <= '0;
         sol_valid_q   <= 1'b0;
         match_count_q <= '0;
         last_hit_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         target_q      <= target_d;
         sol_a_q       <= sol_a_d;
         sol_b_q       <= sol_b_d;
         sol_valid_q   <= sol_valid_d;
         match_count_q <= match_count_d;
         last_hit_q    <= last_hit_d;
      end
   end

   assign tgt_ready   = (state_q == S_IDLE);
   assign busy        = (state_q != S_IDLE);
   assign done        = (state_q == S_DONE);
   assign sol_valid   = sol_valid_q;
   assign sol_a       = sol_a_q;
   assign sol_b       = sol_b_q;
   assign match_count = match_count_q;

endmodule

// File: tb/tb_bm_dag3_solver.sv
// Directed bench for bm_dag3_solver (BITS=2): solution streams, done timing,
// backpressure, ignored targets during a scan and reset while emitting.
module tb_bm_dag3_solver;

   logic       clock;
   logic       reset_n;
   logic       tgt_valid;
   logic       tgt_ready;
   logic [1:0] tgt_value;
   logic       sol_valid;
   logic       sol_ready;
   logic [1:0] sol_a;
   logic [1:0] sol_b;
   logic       done;
   logic [4:0] match_count;
   logic       busy;

   int vectors;
   int miscompares;

   logic [3:0] obs [16];
   int         obs_n;
   int         done_cycle;
   int         done_pulses;
   int         ready_seen;
   int         stall_seen;
   bit         stall_stable;
   logic [4:0] mc_done;

   // f reduces to 2*(x+y) mod 4, so even targets hit 8 pairs and odd ones none
   logic [3:0] exp_t0 [8] = '{4'h0, 4'h2, 4'h5, 4'h7, 4'h8, 4'hA, 4'hD, 4'hF};
   logic [3:0] exp_t2 [8] = '{4'h1, 4'h3, 4'h4, 4'h6, 4'h9, 4'hB, 4'hC, 4'hE};

   bm_dag3_solver #(.BITS(2)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .tgt_valid   (tgt_valid),
      .tgt_ready   (tgt_ready),
      .tgt_value   (tgt_value),
      .sol_valid   (sol_valid),
      .sol_ready   (sol_ready),
      .sol_a       (sol_a),
      .sol_b       (sol_b),
      .done        (done),
      .match_count (match_count),
      .busy        (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Offers one target and observes a fixed window; cycle k is the k-th cycle after acceptance.
   task automatic run_target(input logic [1:0] v, input int stall, input bit inject);
      int         stall_left;
      bit         have_hold;
      logic [1:0] ha, hb;
      obs_n        = 0;
      done_cycle   = -1;
      done_pulses  = 0;
      ready_seen   = 0;
      stall_seen   = 0;
      stall_stable = 1'b1;
      mc_done      = '0;
      stall_left   = stall;
      have_hold    = 1'b0;
      ha           = '0;
      hb           = '0;
      @(negedge clock);
      tgt_value = v;
      tgt_valid = 1'b1;
      sol_ready = (stall == 0);
      @(negedge clock);
      tgt_valid = 1'b0;
      for (int k = 1; k <= 60; k++) begin
         if (tgt_ready && done_cycle < 0) ready_seen++;
         if (done) begin
            done_pulses++;
            if (done_cycle < 0) begin
               done_cycle = k;
               mc_done    = match_count;
            end
         end
         if (inject && k == 3) begin
            tgt_value = 2'd1;
            tgt_valid = 1'b1;
         end
         if (inject && k == 5) tgt_valid = 1'b0;
         if (sol_valid) begin
            if (stall_left > 0) begin
               if (!have_hold) begin
                  ha        = sol_a;
                  hb        = sol_b;
                  have_hold = 1'b1;
               end else if (sol_a !== ha || sol_b !== hb) begin
                  stall_stable = 1'b0;
               end
               stall_seen++;
               stall_left--;
            end else begin
               sol_ready = 1'b1;
               if (obs_n < 16) obs[obs_n] = {sol_a, sol_b};
               obs_n++;
            end
         end
         @(negedge clock);
      end
      tgt_valid = 1'b0;
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clock);
      vectors += 6;
      if (tgt_ready !== 1'b1) begin miscompares++; $display("FAIL reset_tgt_ready: got %b expected 1", tgt_ready); end
      if (sol_valid !== 1'b0) begin miscompares++; $display("FAIL reset_sol_valid: got %b expected 0", sol_valid); end
      if ({sol_a, sol_b} !== 4'h0) begin miscompares++; $display("FAIL reset_sol_ab: got %h expected 0", {sol_a, sol_b}); end
      if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
      if (match_count !== 5'd0) begin miscompares++; $display("FAIL reset_match_count: got %0d expected 0", match_count); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
      reset_n = 1'b1;
      @(negedge clock);
      vectors += 2;
      if (tgt_ready !== 1'b1) begin miscompares++; $display("FAIL post_reset_tgt_ready: got %b expected 1", tgt_ready); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
   endtask

   task automatic test_even_target(input logic [1:0] v, input bit use_t2, input int stall,
                                   input bit inject, input int exp_done);
      logic [3:0] e;
      run_target(v, stall, inject);
      vectors += 7;
      if (done_cycle !== exp_done) begin miscompares++; $display("FAIL t%0d_done_cycle: got %0d expected %0d", v, done_cycle, exp_done); end
      if (done_pulses !== 1) begin miscompares++; $display("FAIL t%0d_done_pulses: got %0d expected 1", v, done_pulses); end
      if (mc_done !== 5'd8) begin miscompares++; $display("FAIL t%0d_mc_at_done: got %0d expected 8", v, mc_done); end
      if (obs_n !== 8) begin miscompares++; $display("FAIL t%0d_solution_count: got %0d expected 8", v, obs_n); end
      if (ready_seen !== 0) begin miscompares++; $display("FAIL t%0d_tgt_ready_during_scan: got %0d cycles expected 0", v, ready_seen); end
      if (match_count !== 5'd8) begin miscompares++; $display("FAIL t%0d_mc_held: got %0d expected 8", v, match_count); end
      if (tgt_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL t%0d_idle_after: got ready=%b busy=%b expected 1 0", v, tgt_ready, busy); end
      for (int i = 0; i < 8; i++) begin
         e = use_t2 ? exp_t2[i] : exp_t0[i];
         vectors++;
         if (i >= obs_n || obs[i] !== e) begin
            miscompares++;
            $display("FAIL t%0d_pair%0d: got a=%0d b=%0d expected a=%0d b=%0d", v, i,
                     obs[i][3:2], obs[i][1:0], e[3:2], e[1:0]);
         end
      end
      if (stall > 0) begin
         vectors += 2;
         if (stall_seen !== stall) begin miscompares++; $display("FAIL stall_cycles_valid: got %0d expected %0d", stall_seen, stall); end
         if (stall_stable !== 1'b1) begin miscompares++; $display("FAIL stall_pair_stable: got %b expected 1", stall_stable); end
      end
   endtask

   task automatic test_odd_targets;
      logic [1:0] v;
      for (int t = 0; t < 2; t++) begin
         v = (t == 0) ? 2'd1 : 2'd3;
         run_target(v, 0, 1'b0);
         vectors += 5;
         if (done_cycle !== 17) begin miscompares++; $display("FAIL t%0d_done_cycle: got %0d expected 17", v, done_cycle); end
         if (done_pulses !== 1) begin miscompares++; $display("FAIL t%0d_done_pulses: got %0d expected 1", v, done_pulses); end
         if (obs_n !== 0) begin miscompares++; $display("FAIL t%0d_solutions: got %0d expected 0", v, obs_n); end
         if (mc_done !== 5'd0) begin miscompares++; $display("FAIL t%0d_mc: got %0d expected 0", v, mc_done); end
         if (ready_seen !== 0) begin miscompares++; $display("FAIL t%0d_tgt_ready_during_scan: got %0d cycles expected 0", v, ready_seen); end
      end
   endtask

   task automatic test_reset_in_emit;
      bit seen;
      @(negedge clock);
      tgt_value = 2'd0;
      tgt_valid = 1'b1;
      sol_ready = 1'b0;
      @(negedge clock);
      tgt_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (sol_valid) seen = 1'b1;
         else @(negedge clock);
      end
      vectors++;
      if (!seen) begin miscompares++; $display("FAIL emit_reached: got 0 expected 1"); end
      reset_n = 1'b0;
      #1;
      vectors += 4;
      if (sol_valid !== 1'b0) begin miscompares++; $display("FAIL rst_emit_sol_valid: got %b expected 0", sol_valid); end
      if (tgt_ready !== 1'b1) begin miscompares++; $display("FAIL rst_emit_tgt_ready: got %b expected 1", tgt_ready); end
      if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_emit_busy: got %b expected 0", busy); end
      if (match_count !== 5'd0) begin miscompares++; $display("FAIL rst_emit_mc: got %0d expected 0", match_count); end
      @(negedge clock);
      reset_n   = 1'b1;
      sol_ready = 1'b1;
      test_even_target(2'd2, 1'b1, 0, 1'b0, 25);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      reset_n     = 1'b0;
      tgt_valid   = 1'b0;
      tgt_value   = '0;
      sol_ready   = 1'b0;
      test_reset();
      test_even_target(2'd0, 1'b0, 0, 1'b0, 25);
      test_even_target(2'd2, 1'b1, 0, 1'b0, 25);
      test_odd_targets();
      test_even_target(2'd0, 1'b0, 5, 1'b0, 30);
      test_even_target(2'd0, 1'b0, 0, 1'b1, 25);
      test_reset_in_emit();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
